bcd2bin_seq: RTL and testbench

Sequential BCD-to-binary converter; the inverse of the team's combinational binary-to-BCD block. Takes four packed BCD digits (0000–9999) and produces a 14-bit unsigned binary value using iterative reverse double-dabble: shift right, then subtract 3 from each BCD digit that is 8 or more. Sits between keypad/digit-entry logic and arithmetic datapaths. Uses a start/done handshake and one shift iteration per clock.

---
 rtl/bcd2bin_pkg.sv | 14 +
 rtl/bcd2bin_digit_adj.sv | 17 +
 rtl/bcd2bin_seq.sv | 128 ++++++++++++
 tb/tb_bcd2bin_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd2bin_pkg.sv
// Shared constants for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

  localparam int unsigned BIN_W    = 14;
  localparam int unsigned N_DIGITS = 4;
  localparam int unsigned SHIFT_W  = 30;
  localparam int unsigned N_ITER   = 14;
  localparam int unsigned CNT_W    = 4;

  // FSM encoding
  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

endpackage

// File: rtl/bcd2bin_digit_adj.sv
// Reverse double-dabble digit correction: a BCD nibble that reads 8 or more
// after a right shift had a 1 shifted in from the digit above, worth 5 here
// rather than 8, so 3 is removed.
module bcd2bin_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Conditional subtract-3 on one nibble
  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd8) begin
      d_o = d_i - 4'd3;
    end
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one shift iteration per clock.
// Optional feature: define BCD2BIN_DIGIT_CHECK_EN to reject digits above 9
// with a one-cycle done+err response instead of running the conversion.
module bcd2bin_seq
  import bcd2bin_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       thousands,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] binary,
  output logic             err
);

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               pend_q, pend_d;  // invalid digits seen, respond next edge
  logic               bad_digit;

  logic [SHIFT_W-1:0] shifted;
  logic [SHIFT_W-1:0] shift_nx;
  logic [3:0]         adj [N_DIGITS];

`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign bad_digit = (thousands > 4'd9) || (hundreds > 4'd9) ||
                     (tens > 4'd9) || (ones > 4'd9);
`else
  assign bad_digit = 1'b0;
`endif

  assign shifted = shift_q >> 1;

  // Four digit correctors on the BCD nibbles of the shifted value
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd2bin_digit_adj u_adj (
      .d_i (shifted[BIN_W + 4*g +: 4]),
      .d_o (adj[g])
    );
  end

  assign shift_nx = {adj[3], adj[2], adj[1], adj[0], shifted[BIN_W-1:0]};

  // Next-state logic for the handshake FSM and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pend_d  = 1'b0;

    if (pend_q) begin
      done_d = 1'b1;
      err_d  = 1'b1;
      bin_d  = '0;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          if (bad_digit) begin
            pend_d = 1'b1;
          end else begin
            shift_d = {thousands, hundreds, tens, ones, {BIN_W{1'b0}}};
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        shift_d = shift_nx;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_ITER - 1)) begin
          bin_d   = shift_nx[BIN_W-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign binary = bin_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed cases plus random valid digits
// compared against a decimal-arithmetic reference.
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic        busy, done, err;
  logic [13:0] binary;

  int n_vec;
  int n_err;

  bcd2bin_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .busy      (busy),
    .done      (done),
    .binary    (binary),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal weighting of the digits
  function automatic int ref_bin(input int th, input int h, input int t, input int o);
    return th * 1000 + h * 100 + t * 10 + o;
  endfunction

  task automatic set_digits(input int th, input int h, input int t, input int o);
    thousands = 4'(th);
    hundreds  = 4'(h);
    tens      = 4'(t);
    ones      = 4'(o);
  endtask

  // Waits (bounded) for done; cyc counts edges since the accepting edge
  task automatic wait_done(output int b, output int e, output int cyc, output int busy_ok);
    cyc     = 0;
    busy_ok = 1;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (!done && !busy) busy_ok = 0;
    end while (!done && cyc < 40);
    if (!done) check_eq("done_timeout", 0, 1);
    b = int'(binary);
    e = int'(err);
  endtask

  // One complete conversion of valid digits with full timing checks
  task automatic run_conv(input string tag, input int th, input int h, input int t,
                          input int o);
    int b, e, cyc, bok;
    @(posedge clk);
    #1;
    set_digits(th, h, t, o);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, "_busy_after_accept"}, int'(busy), 1);
    wait_done(b, e, cyc, bok);
    check_eq({tag, "_latency"}, cyc, 14);
    check_eq({tag, "_binary"}, b, ref_bin(th, h, t, o));
    check_eq({tag, "_err"}, e, 0);
    check_eq({tag, "_busy_held"}, bok, 1);
    check_eq({tag, "_busy_at_done"}, int'(busy), 0);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_one_cycle"}, int'(done), 0);
  endtask

  initial begin
    int b, e, cyc, bok, seen;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    set_digits(0, 0, 0, 0);
    #12;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_binary", int'(binary), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_conv("d9999", 9, 9, 9, 9);
    run_conv("d0000", 0, 0, 0, 0);
    run_conv("d1234", 1, 2, 3, 4);

    for (int i = 0; i < 20; i++) begin
      run_conv("rand", $urandom_range(9), $urandom_range(9), $urandom_range(9),
               $urandom_range(9));
    end

    // start pulsed mid-conversion with new digits is ignored
    @(posedge clk);
    #1;
    set_digits(0, 0, 4, 2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    set_digits(9, 9, 9, 9);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 5;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("ignore_latency", cyc, 14);
    check_eq("ignore_binary", int'(binary), 42);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    check_eq("ignore_no_second_done", seen, 0);

    // start held high: back-to-back conversions, inputs sampled only on accept
    @(posedge clk);
    #1;
    set_digits(0, 1, 0, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    set_digits(0, 0, 0, 7);
    wait_done(b, e, cyc, bok);
    check_eq("b2b_first_latency", cyc, 14);
    check_eq("b2b_first_binary", b, 100);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("b2b_reaccept_busy", int'(busy), 1);
    wait_done(b, e, cyc, bok);
    check_eq("b2b_second_latency", cyc, 14);
    check_eq("b2b_second_binary", b, 7);

    // asynchronous reset in the middle of a conversion
    @(posedge clk);
    #1;
    set_digits(1, 2, 3, 4);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_done", int'(done), 0);
    check_eq("midrst_err", int'(err), 0);
    check_eq("midrst_binary", int'(binary), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1;
    end
    check_eq("midrst_no_done", seen, 0);

    // invalid tens digit
    @(posedge clk);
    #1;
    set_digits(0, 0, 10, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    check_eq("bad_busy", int'(busy), 0);
    wait_done(b, e, cyc, bok);
    check_eq("bad_latency", cyc, 1);
    check_eq("bad_err", e, 1);
    check_eq("bad_binary", b, 0);
`else
    check_eq("bad_busy", int'(busy), 1);
    wait_done(b, e, cyc, bok);
    check_eq("bad_latency", cyc, 14);
    check_eq("bad_err", e, 0);
`endif
    @(posedge clk);
    #1;
    check_eq("bad_done_one_cycle", int'(done), 0);
    check_eq("bad_err_cleared", int'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
